// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter for two requesters sharing a 256x8 single-port RAM, with a fill sequencer.
// Latency: grant is combinational, read data valid one cycle after the grant edge; clear holds off all grants.
module sp_ram_arbiter #(
    parameter int              AW   = 8,
    parameter int              DW   = 8,
    parameter logic [DW-1:0]   FILL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_start,
    output logic          busy,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_reset,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [AW:0] CLR_LAST = {1'b0, {AW{1'b1}}};

    state_t        state, state_nxt;
    logic [AW:0]   clr_cnt, clr_cnt_nxt;
    logic          last_gnt;          // 1 = B was granted last
    logic          rv_q;
    logic          rv_owner;          // 1 = pending read data belongs to B
    logic [AW-1:0] ad_q;
    logic [DW-1:0] din_q;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        ram_ce      = 1'b0;
        ram_wre     = 1'b0;
        ram_ad      = ad_q;
        ram_din     = din_q;
        case (state)
            CLEAR: begin
                busy        = 1'b1;
                ram_ce      = 1'b1;
                ram_wre     = 1'b1;
                ram_ad      = clr_cnt[AW-1:0];
                ram_din     = FILL;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end
            end
            IDLE: begin
                if (clr_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else if (!reset) begin
                    a_gnt = a_req & (~b_req | last_gnt);
                    b_gnt = b_req & (~a_req | ~last_gnt);
                    if (a_gnt) begin
                        ram_ce  = 1'b1;
                        ram_wre = a_we;
                        ram_ad  = a_addr;
                        ram_din = a_wdata;
                    end else if (b_gnt) begin
                        ram_ce  = 1'b1;
                        ram_wre = b_we;
                        ram_ad  = b_addr;
                        ram_din = b_wdata;
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            last_gnt <= 1'b1;
            rv_q     <= 1'b0;
            rv_owner <= 1'b0;
            ad_q     <= '0;
            din_q    <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            rv_q    <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
            if (a_gnt | b_gnt) begin
                last_gnt <= b_gnt;
                rv_owner <= b_gnt;
            end
            ad_q  <= ram_ad;
            din_q <= ram_din;
        end
    end

    // Reset kills a read whose data would land in the reset cycle.
    assign a_rvalid  = rv_q & ~rv_owner & ~reset;
    assign b_rvalid  = rv_q &  rv_owner & ~reset;
    assign a_rdata   = ram_dout;
    assign b_rdata   = ram_dout;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

endmodule
